// File: rtl/instr_mem_fetch_if.sv
// Load/fetch bus between the pipeline front end and the program memory.
interface instr_mem_fetch_if #(
  parameter int unsigned DATA_W = 28,
  parameter int unsigned ADDR_W = 16
);
  logic              iLoadEn;
  logic [ADDR_W-1:0] iLoadAddr;
  logic [DATA_W-1:0] iLoadData;
  logic              iFetchEn;
  logic [ADDR_W-1:0] iAddress;
  logic              iStall;
  logic              iFlush;
  logic              oReady;
  logic [DATA_W-1:0] oInstruction;
  logic [ADDR_W-1:0] oPC;
  logic              oValid;
  logic              oOutOfRange;

  modport master (
    output iLoadEn, iLoadAddr, iLoadData, iFetchEn, iAddress, iStall, iFlush,
    input  oReady, oInstruction, oPC, oValid, oOutOfRange
  );

  modport slave (
    input  iLoadEn, iLoadAddr, iLoadData, iFetchEn, iAddress, iStall, iFlush,
    output oReady, oInstruction, oPC, oValid, oOutOfRange
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// Loadable program memory with a registered fetch stage and a post-reset
// clear sequence that fills every word with NOP before fetch is enabled.
module instr_mem_fetch #(
  parameter int unsigned        DATA_W   = 28,
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        DEPTH    = 256,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(0)
) (
  input  logic               Clock,
  input  logic               Reset,
  instr_mem_fetch_if.slave   bus
);

  localparam int unsigned      IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]  DEPTH_CMP = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_clr_cnt;
  logic [IDX_W-1:0]    w_clr_cnt_nxt;
  logic                r_ready;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [DATA_W-1:0]   r_instr;
  logic [DATA_W-1:0]   w_instr_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_oor;
  logic                w_oor_nxt;

  logic                w_load_hit;
  logic                w_fetch_hit;
  logic [IDX_W-1:0]    w_load_idx;
  logic [IDX_W-1:0]    w_fetch_idx;
  logic [DATA_W-1:0]   w_fetch_word;

  logic                w_mem_we;
  logic [IDX_W-1:0]    w_mem_widx;
  logic [DATA_W-1:0]   w_mem_wdata;

  // Full-width range checks; the low index bits are only used once a check passes.
  assign w_load_hit   = {1'b0, bus.iLoadAddr} < DEPTH_CMP;
  assign w_fetch_hit  = {1'b0, bus.iAddress}  < DEPTH_CMP;
  assign w_load_idx   = bus.iLoadAddr[IDX_W-1:0];
  assign w_fetch_idx  = bus.iAddress[IDX_W-1:0];
  // Read of the pre-edge contents gives read-first behaviour on a collision.
  assign w_fetch_word = r_mem[w_fetch_idx];

  // State, clear counter and ready flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_ready   <= (w_state_nxt == ST_RUN);
    end
  end

  // Next state, memory write port and next output register values.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_mem_we      = 1'b0;
    w_mem_widx    = w_load_idx;
    w_mem_wdata   = bus.iLoadData;
    w_instr_nxt   = r_instr;
    w_pc_nxt      = r_pc;
    w_valid_nxt   = r_valid;
    w_oor_nxt     = r_oor;

    case (r_state)
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_widx  = r_clr_cnt;
        w_mem_wdata = NOP_WORD;
        if (r_clr_cnt == LAST_IDX) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + IDX_W'(1);
        end
      end
      ST_RUN: begin
        w_mem_we = bus.iLoadEn && w_load_hit;
        if (bus.iFlush) begin
          w_instr_nxt = NOP_WORD;
          w_valid_nxt = 1'b0;
          w_oor_nxt   = 1'b0;
        end else if (bus.iStall) begin
          w_instr_nxt = r_instr;
        end else if (bus.iFetchEn) begin
          w_pc_nxt    = bus.iAddress;
          w_valid_nxt = 1'b1;
          w_oor_nxt   = !w_fetch_hit;
          w_instr_nxt = w_fetch_hit ? w_fetch_word : NOP_WORD;
        end else begin
          w_instr_nxt = NOP_WORD;
          w_valid_nxt = 1'b0;
          w_oor_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // Single write port shared by the clear sequence and the load port.
  always_ff @(posedge Clock) begin
    if (!Reset && w_mem_we) begin
      r_mem[w_mem_widx] <= w_mem_wdata;
    end
  end

  // Fetch output register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_instr <= NOP_WORD;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_oor   <= 1'b0;
    end else begin
      r_instr <= w_instr_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_oor   <= w_oor_nxt;
    end
  end

  assign bus.oReady       = r_ready;
  assign bus.oInstruction = r_instr;
  assign bus.oPC          = r_pc;
  assign bus.oValid       = r_valid;
  assign bus.oOutOfRange  = r_oor;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch (DEPTH = 16): directed table, corner sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_instr_mem_fetch;

  localparam int unsigned DW = 28;
  localparam int unsigned AW = 16;
  localparam int unsigned DEP = 16;
  localparam logic [DW-1:0] NOP = 28'd0;
  localparam logic [DW-1:0] W_STO = {8'h01, 4'h1, 16'd5};
  localparam logic [DW-1:0] W_ADD = {8'h02, 4'h1, 4'h1, 4'h0, 8'h00};

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int failures = 0;

  instr_mem_fetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  instr_mem_fetch #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NOP_WORD(NOP)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  // Behavioural model state
  logic [DW-1:0] m_mem [DEP];
  int            m_clr;
  bit            m_ready;
  logic [DW-1:0] e_instr;
  logic [AW-1:0] e_pc;
  bit            e_valid;
  bit            e_oor;

  typedef struct {
    bit            le;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    bit            fe;
    logic [AW-1:0] fa;
    bit            st;
    bit            fl;
    bit            ev;
    logic [DW-1:0] ei;
    logic [AW-1:0] ep;
    bit            eo;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(bit le, logic [AW-1:0] la, logic [DW-1:0] ld,
                              bit fe, logic [AW-1:0] fa, bit st, bit fl,
                              bit ev, logic [DW-1:0] ei, logic [AW-1:0] ep, bit eo);
    vec_t v;
    v.le = le; v.la = la; v.ld = ld; v.fe = fe; v.fa = fa; v.st = st; v.fl = fl;
    v.ev = ev; v.ei = ei; v.ep = ep; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Spec-level model of one clock edge.
  task automatic model_edge(input bit rst, input bit le, input logic [AW-1:0] la,
                            input logic [DW-1:0] ld, input bit fe,
                            input logic [AW-1:0] fa, input bit st, input bit fl);
    if (rst) begin
      e_instr = NOP; e_pc = '0; e_valid = 0; e_oor = 0;
      m_clr = 0; m_ready = 0;
    end else if (!m_ready) begin
      m_clr++;
      if (m_clr == int'(DEP)) begin
        m_ready = 1;
        for (int i = 0; i < int'(DEP); i++) m_mem[i] = NOP;
      end
    end else begin
      if (fl) begin
        e_instr = NOP; e_valid = 0; e_oor = 0;
      end else if (st) begin
        // hold
      end else if (fe) begin
        e_pc = fa; e_valid = 1;
        if (int'(fa) < int'(DEP)) begin
          e_instr = m_mem[int'(fa)]; e_oor = 0;
        end else begin
          e_instr = NOP; e_oor = 1;
        end
      end else begin
        e_instr = NOP; e_valid = 0; e_oor = 0;
      end
      if (le && int'(la) < int'(DEP)) m_mem[int'(la)] = ld;
    end
  endtask

  // Drive one cycle, advance the model, and compare every output with it.
  task automatic step(input bit rst, input bit le, input logic [AW-1:0] la,
                      input logic [DW-1:0] ld, input bit fe,
                      input logic [AW-1:0] fa, input bit st, input bit fl);
    Reset = rst;
    bus.iLoadEn = le; bus.iLoadAddr = la; bus.iLoadData = ld;
    bus.iFetchEn = fe; bus.iAddress = fa; bus.iStall = st; bus.iFlush = fl;
    @(posedge Clock);
    model_edge(rst, le, la, ld, fe, fa, st, fl);
    #1;
    chk("model_instr", 32'(bus.oInstruction), 32'(e_instr));
    chk("model_pc",    32'(bus.oPC),          32'(e_pc));
    chk("model_valid", 32'(bus.oValid),       32'(e_valid));
    chk("model_oor",   32'(bus.oOutOfRange),  32'(e_oor));
    chk("model_ready", 32'(bus.oReady),       32'(m_ready));
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    step(0, 0, '0, '0, 1, a, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, '0, '0, 0, '0, 0, 0);
    chk("rst_instr", 32'(bus.oInstruction), 32'(NOP));
    chk("rst_pc",    32'(bus.oPC), 32'd0);
    chk("rst_valid", 32'(bus.oValid), 32'd0);
    chk("rst_oor",   32'(bus.oOutOfRange), 32'd0);
    chk("rst_ready", 32'(bus.oReady), 32'd0);
  endtask

  // Count cycles from reset release until oReady; a missing rise still lands in the check.
  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!bus.oReady && n < 40) begin
      idle();
      n++;
    end
    chk(nm, 32'(n), 32'd16);
  endtask

  initial begin
    bus.iLoadEn = 0; bus.iLoadAddr = '0; bus.iLoadData = '0;
    bus.iFetchEn = 0; bus.iAddress = '0; bus.iStall = 0; bus.iFlush = 0;

    tbl[0]  = mk(1, 16'd1,  W_STO,        0, 16'd0,      0, 0, 0, NOP,          16'd15,     0);
    tbl[1]  = mk(1, 16'd4,  W_ADD,        0, 16'd0,      0, 0, 0, NOP,          16'd15,     0);
    tbl[2]  = mk(1, 16'd2,  28'h0000003,  0, 16'd0,      0, 0, 0, NOP,          16'd15,     0);
    tbl[3]  = mk(0, 16'd0,  '0,           1, 16'd1,      0, 0, 1, W_STO,        16'd1,      0);
    tbl[4]  = mk(0, 16'd0,  '0,           1, 16'd4,      0, 0, 1, W_ADD,        16'd4,      0);
    tbl[5]  = mk(0, 16'd0,  '0,           1, 16'd1,      0, 0, 1, W_STO,        16'd1,      0);
    tbl[6]  = mk(0, 16'd0,  '0,           1, 16'd4,      1, 0, 1, W_STO,        16'd1,      0);
    tbl[7]  = mk(0, 16'd0,  '0,           1, 16'd4,      1, 0, 1, W_STO,        16'd1,      0);
    tbl[8]  = mk(0, 16'd0,  '0,           1, 16'd4,      1, 0, 1, W_STO,        16'd1,      0);
    tbl[9]  = mk(0, 16'd0,  '0,           1, 16'd4,      1, 1, 0, NOP,          16'd1,      0);
    tbl[10] = mk(0, 16'd0,  '0,           1, 16'h0010,   0, 0, 1, NOP,          16'h0010,   1);
    tbl[11] = mk(0, 16'd0,  '0,           1, 16'hFFFF,   0, 0, 1, NOP,          16'hFFFF,   1);
    tbl[12] = mk(1, 16'd20, 28'hFFFFFFF,  0, 16'd0,      0, 0, 0, NOP,          16'hFFFF,   0);
    tbl[13] = mk(0, 16'd0,  '0,           1, 16'd4,      0, 0, 1, W_ADD,        16'd4,      0);
    tbl[14] = mk(1, 16'd2,  28'hABCDEF0,  1, 16'd2,      0, 0, 1, 28'h0000003,  16'd2,      0);
    tbl[15] = mk(0, 16'd0,  '0,           1, 16'd2,      0, 0, 1, 28'hABCDEF0,  16'd2,      0);
    tbl[16] = mk(0, 16'd0,  '0,           1, 16'd3,      0, 1, 0, NOP,          16'd2,      0);

    // Clear sequence length and contents
    do_reset();
    wait_ready("clear_len");
    for (int a = 0; a < int'(DEP); a++) begin
      fetch(AW'(a));
      chk($sformatf("clear_word[%0d]", a), 32'(bus.oInstruction), 32'(NOP));
      chk($sformatf("clear_valid[%0d]", a), 32'(bus.oValid), 32'd1);
    end

    // Directed table: load/fetch, stall/flush, out-of-range, collision
    for (int i = 0; i < 17; i++) begin
      step(0, tbl[i].le, tbl[i].la, tbl[i].ld, tbl[i].fe, tbl[i].fa, tbl[i].st, tbl[i].fl);
      chk($sformatf("tbl_instr[%0d]", i), 32'(bus.oInstruction), 32'(tbl[i].ei));
      chk($sformatf("tbl_pc[%0d]", i),    32'(bus.oPC),          32'(tbl[i].ep));
      chk($sformatf("tbl_valid[%0d]", i), 32'(bus.oValid),       32'(tbl[i].ev));
      chk($sformatf("tbl_oor[%0d]", i),   32'(bus.oOutOfRange),  32'(tbl[i].eo));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit le, fe, st, fl, rst;
      logic [AW-1:0] la, fa;
      logic [DW-1:0] ld;
      rst = ($urandom_range(0, 149) == 0);
      le  = ($urandom_range(0, 2) == 0);
      fe  = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 5) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      la  = ($urandom_range(0, 4) != 0) ? AW'($urandom_range(0, DEP - 1)) : AW'($urandom);
      fa  = ($urandom_range(0, 4) != 0) ? AW'($urandom_range(0, DEP - 1)) : AW'($urandom);
      ld  = DW'($urandom);
      step(rst, le, la, ld, fe, fa, st, fl);
    end

    // Reset in the middle of the clear sequence
    do_reset();
    for (int i = 0; i < 7; i++) idle();
    do_reset();
    wait_ready("clear_len_after_abort");

    // Reset in RUN after loads: loaded words must come back as NOP
    step(0, 1, 16'd3, 28'h1234567, 0, '0, 0, 0);
    step(0, 1, 16'd5, 28'h7654321, 0, '0, 0, 0);
    fetch(16'd3);
    chk("pre_reset_word3", 32'(bus.oInstruction), 32'h01234567);
    do_reset();
    wait_ready("clear_len_after_run");
    fetch(16'd3);
    chk("post_reset_word3", 32'(bus.oInstruction), 32'(NOP));
    fetch(16'd5);
    chk("post_reset_word5", 32'(bus.oInstruction), 32'(NOP));
    chk("post_reset_pc", 32'(bus.oPC), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised, loadable program memory with a registered fetch stage. It replaces the hard-coded combinational instruction ROM that feeds the processor pipeline.
- Programs are written through a load port, so test programs no longer require an RTL edit.
- Reads are synchronous and the output register supports pipeline stall and flush.
- After reset, an internal FSM clears every word to the NOP encoding before fetch is enabled.

Parameters:
- DATA_W, 28, instruction width in bits (opcode plus operand fields).
- ADDR_W, 16, address width of iAddress and iLoadAddr.
- DEPTH, 256, number of implemented words; must be ≤ 2^ADDR_W.
- NOP_WORD, 28'd0, word returned on reset, flush, clear, or out-of-range fetch.

Ports:
- Clock  in  1  system clock; all logic rising-edge.
- Reset  in  1  synchronous, active-high reset.
- iLoadEn  in  1  write strobe for the program load port.
- iLoadAddr  in  ADDR_W  load address.
- iLoadData  in  DATA_W  load data.
- iFetchEn  in  1  request a fetch of iAddress this cycle.
- iAddress  in  ADDR_W  fetch address (PC).
- iStall  in  1  hold output registers.
- iFlush  in  1  squash the fetched instruction.
- oReady  out  1  high once the clear sequence has finished.
- oInstruction  out  DATA_W  registered fetched instruction.
- oPC  out  ADDR_W  address that oInstruction came from.
- oValid  out  1  oInstruction is a real fetch.
- oOutOfRange  out  1  last fetch address was ≥ DEPTH.

Behaviour:
- Reset values:
  - oInstruction = NOP_WORD, oPC = 0, oValid = 0, oOutOfRange = 0, oReady = 0.
  - FSM goes to CLEAR with clear counter = 0.
  - Reset mid-operation aborts everything, including a clear in progress, and restarts CLEAR.
- FSM states: CLEAR and RUN.
  - CLEAR: writes NOP_WORD to word[counter] and increments the counter each cycle. After writing DEPTH-1 it moves to RUN, so CLEAR lasts exactly DEPTH cycles.
  - In CLEAR, iLoadEn, iFetchEn, iStall and iFlush are ignored. Outputs keep their reset values.
  - RUN: oReady = 1. The FSM stays in RUN until Reset.
- Load (RUN only):
  - iLoadEn = 1 with iLoadAddr < DEPTH writes iLoadData at the clock edge.
  - iLoadAddr ≥ DEPTH is silently dropped.
- Fetch latency is 1 cycle. With iFetchEn = 1 in cycle N, oInstruction/oPC/oValid show the result from edge N+1 onward.
- Output register priority at each edge: Reset > iFlush > iStall > iFetchEn.
  - iFlush: oInstruction = NOP_WORD, oValid = 0, oOutOfRange = 0, oPC unchanged. Flush overrides stall.
  - iStall (no flush): all outputs hold. A fetch request in the same cycle is discarded; the requester re-presents it.
  - iFetchEn only: oPC = iAddress, oValid = 1.
    - If iAddress < DEPTH: oInstruction = word[iAddress], oOutOfRange = 0.
    - Else: oInstruction = NOP_WORD, oOutOfRange = 1.
  - None of the above: oValid = 0, oInstruction = NOP_WORD, oPC holds, oOutOfRange = 0.
- Read/write collision: a load and a fetch to the same address in the same cycle is read-first. The fetch returns the old word; the new word is visible from the next fetch.
- Address arithmetic:
  - The range check uses the full ADDR_W-bit compare against DEPTH.
  - Memory indexing uses the low ceil(log2 DEPTH) bits only after the check passes.
  - There is no wrap-around.
- Memory array reset: the array is not reset directly; contents are defined only after CLEAR completes.

Test Plan:
- Clear sequence (DEPTH = 16):
  - Stimulus: Reset high 1 cycle, then low.
  - Required: oReady rises exactly 16 cycles later. Fetch of each address 0..15 returns 28'd0 with oValid = 1.
- Load and fetch:
  - Stimulus: load addr 1 = {STO,R1,16'd5}, addr 4 = {ADD,R1,R1,R0}; fetch 1 then 4 back-to-back.
  - Required: those words appear on consecutive cycles, each one cycle after its request, with oPC = 1 then 4.
- Stall/flush:
  - Stimulus: fetch addr 1, stall 3 cycles while presenting addr 4, then assert flush and stall together.
  - Required: addr-1 word and oPC = 1 hold during the stall. Next cycle after the flush shows oValid = 0 and NOP_WORD.
- Out-of-range:
  - Stimulus: fetch addr 16'h0010 and 16'hFFFF with DEPTH = 16; load to addr 20.
  - Required: both fetches give NOP_WORD with oValid = 1 and oOutOfRange = 1. Word 4 (20 mod 16) is unchanged.
- Collision:
  - Stimulus: load addr 2 = 28'hABCDEF0 while fetching addr 2 (old value 28'h0000003).
  - Required: fetch returns 28'h0000003; next fetch of addr 2 returns 28'hABCDEF0.
- Reset mid-operation:
  - Stimulus: assert Reset at clear count 7 and again during RUN after loads.
  - Required: outputs return to reset values, clear restarts from 0, oReady reappears after 16 cycles, and loaded words read back as NOP_WORD.
